// File: rtl/alu_issue_seq.sv
// Command issuer for the 4-bit combinational ALU: buffers commands in a FIFO,
// executes them one per clock against an accumulator, and returns each
// sequence's final value and op count over a valid/ready response port.
module alu_issue_seq #(
  parameter int WIDTH = 4,
  parameter int OPW   = 3,
  parameter int DEPTH = 4,
  parameter int CNTW  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [OPW-1:0]   cmd_op,
  input  logic [WIDTH-1:0] cmd_b,
  input  logic             cmd_load,
  input  logic             cmd_last,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OPW-1:0]   alu_op,
  input  logic [WIDTH-1:0] alu_res,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic [CNTW-1:0]  res_count,
  output logic             busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = OPW + WIDTH + 2;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           state, state_next;
  logic [EW-1:0]    mem [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;
  logic             empty, full, push, pop;
  logic [EW-1:0]    head;
  logic [OPW-1:0]   head_op;
  logic [WIDTH-1:0] head_b;
  logic             head_load, head_last;
  logic             load_q, last_q;
  logic [WIDTH-1:0] acc, acc_next;
  logic [CNTW-1:0]  count, count_next;

  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign push      = cmd_valid && cmd_ready;
  assign head      = mem[rd_ptr[AW-1:0]];
  assign head_op   = head[EW-1 -: OPW];
  assign head_b    = head[WIDTH+1:2];
  assign head_load = head[1];
  assign head_last = head[0];

  // FIFO storage: entries are {op, b, load, last}
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= {cmd_op, cmd_b, cmd_load, cmd_last};
  end

  // FIFO pointers, one extra wrap bit to tell full from empty
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next state and pop decision; a non-last EXEC chains straight into the next command
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop        = 1'b1;
          state_next = EXEC;
        end
      end
      EXEC: begin
        if (last_q) begin
          state_next = RESP;
        end else if (!empty) begin
          pop        = 1'b1;
          state_next = EXEC;
        end else begin
          state_next = IDLE;
        end
      end
      RESP: begin
        if (res_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs and next accumulator/count values
  always_comb begin
    cmd_ready  = !full;
    busy       = (state != IDLE) || !empty;
    alu_a      = acc;
    acc_next   = load_q ? alu_b : alu_res;
    count_next = count;
    if (!load_q && (count != '1)) count_next = count + 1'b1;
  end

  // Datapath: command registers, accumulator, op count and response hold.
  // alu_b/alu_op are cleared on every non-pop edge so they read zero whenever no command executes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_b     <= '0;
      alu_op    <= '0;
      load_q    <= 1'b0;
      last_q    <= 1'b0;
      acc       <= '0;
      count     <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_count <= '0;
    end else begin
      alu_b  <= pop ? head_b : '0;
      alu_op <= (pop && !head_load) ? head_op : '0;
      load_q <= pop && head_load;
      last_q <= pop && head_last;
      case (state)
        EXEC: begin
          acc   <= acc_next;
          count <= count_next;
          if (last_q) begin
            res_valid <= 1'b1;
            res_data  <= acc_next;
            res_count <= count_next;
          end
        end
        RESP: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            acc       <= '0;
            count     <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_seq.sv
// Testbench for alu_issue_seq: directed sequences with literal expectations,
// plus a sequence-level model of expected responses checked on every handshake.
module tb_alu_issue_seq;
  localparam int WIDTH = 4;
  localparam int OPW   = 3;
  localparam int DEPTH = 4;
  localparam int CNTW  = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [OPW-1:0]   cmd_op = '0;
  logic [WIDTH-1:0] cmd_b = '0;
  logic             cmd_load = 1'b0;
  logic             cmd_last = 1'b0;
  logic [WIDTH-1:0] alu_a, alu_b, alu_res;
  logic [OPW-1:0]   alu_op;
  logic             res_valid;
  logic             res_ready = 1'b1;
  logic [WIDTH-1:0] res_data;
  logic [CNTW-1:0]  res_count;
  logic             busy;

  int total = 0;
  int bad   = 0;

  // Model state: running accumulator/count of the sequence being pushed
  int m_acc = 0;
  int m_cnt = 0;
  int exp_data_q[$];
  int exp_cnt_q[$];

  alu_issue_seq #(.WIDTH(WIDTH), .OPW(OPW), .DEPTH(DEPTH), .CNTW(CNTW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_b(cmd_b),
    .cmd_load(cmd_load), .cmd_last(cmd_last),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_res(alu_res),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_count(res_count), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic int model_alu(input int op, input int a, input int b);
    case (op)
      1: return (a + b) % 16;
      2: return (a - b + 16) % 16;
      3: return a & b;
      4: return a | b;
      5: return (~a) & 15;
      6: return (~b) & 15;
      default: return 0;
    endcase
  endfunction

  // Combinational ALU stand-in
  always_comb alu_res = 4'(model_alu(int'(alu_op), int'(alu_a), int'(alu_b)));

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic model_accept(input int op, input int b, input bit load, input bit last);
    if (load) m_acc = b;
    else begin
      m_acc = model_alu(op, m_acc, b);
      if (m_cnt < (1 << CNTW) - 1) m_cnt++;
    end
    if (last) begin
      exp_data_q.push_back(m_acc);
      exp_cnt_q.push_back(m_cnt);
      m_acc = 0;
      m_cnt = 0;
    end
  endtask

  // Called just after a rising edge; returns just after the accepting edge
  task automatic push(input int op, input int b, input bit load, input bit last);
    bit ok = 1'b0;
    cmd_op    = op[OPW-1:0];
    cmd_b     = b[WIDTH-1:0];
    cmd_load  = load;
    cmd_last  = last;
    cmd_valid = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = cmd_ready;
      @(posedge clk);
    end
    if (ok) model_accept(op, b, load, last);
    else check("push_timeout", 0, 1);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_result(input string name, input int data, input int cnt);
    bit seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      seen = res_valid;
    end
    check({name, "_valid"}, int'(seen), 1);
    check({name, "_data"}, int'(res_data), data);
    check({name, "_count"}, int'(res_count), cnt);
    @(posedge clk); #1;
  endtask

  task automatic wait_idle();
    bit done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      done = !busy && !res_valid;
    end
    check("idle_reached", int'(done), 1);
    @(posedge clk); #1;
  endtask

  // Compare process: every response handshake against the model, and hold stability while stalled
  bit             hold = 1'b0;
  logic [WIDTH-1:0] h_data;
  logic [CNTW-1:0]  h_cnt;
  always @(negedge clk) begin
    if (!rst_n) begin
      hold = 1'b0;
    end else begin
      if (hold) begin
        check("hold_valid", int'(res_valid), 1);
        check("hold_data", int'(res_data), int'(h_data));
        check("hold_count", int'(res_count), int'(h_cnt));
      end
      if (res_valid) begin
        if (res_ready) begin
          if (exp_data_q.size() == 0) begin
            check("unexpected_response", 1, 0);
          end else begin
            check("resp_data", int'(res_data), exp_data_q.pop_front());
            check("resp_count", int'(res_count), exp_cnt_q.pop_front());
          end
        end
        hold   = !res_ready;
        h_data = res_data;
        h_cnt  = res_count;
      end else begin
        hold = 1'b0;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #12;
    check("rst_cmd_ready", int'(cmd_ready), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_res_valid", int'(res_valid), 0);
    check("rst_res_data", int'(res_data), 0);
    check("rst_res_count", int'(res_count), 0);
    check("rst_alu_a", int'(alu_a), 0);
    check("rst_alu_b", int'(alu_b), 0);
    check("rst_alu_op", int'(alu_op), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // load 3, add 1: two back-to-back EXEC cycles then the response
    push(0, 3, 1, 0);
    push(1, 1, 0, 1);
    @(negedge clk);
    check("t1_exec0_op", int'(alu_op), 0);
    check("t1_exec0_b", int'(alu_b), 3);
    check("t1_exec0_a", int'(alu_a), 0);
    @(negedge clk);
    check("t1_exec1_op", int'(alu_op), 1);
    check("t1_exec1_b", int'(alu_b), 1);
    check("t1_exec1_a", int'(alu_a), 3);
    @(negedge clk);
    check("t1_valid", int'(res_valid), 1);
    check("t1_data", int'(res_data), 4);
    check("t1_count", int'(res_count), 1);
    @(posedge clk); #1;
    wait_idle();

    // 1 - 3 wraps to 14
    push(0, 1, 1, 0);
    push(2, 3, 0, 1);
    wait_result("t2", 14, 1);
    wait_idle();

    // load 12, and 10, or 1, not: 8, 9, 6 over consecutive EXEC cycles
    push(0, 12, 1, 0);
    push(3, 10, 0, 0);
    push(4, 1, 0, 0);
    push(5, 0, 0, 1);
    @(negedge clk);
    check("t3_exec2_op", int'(alu_op), 4);
    check("t3_exec2_a", int'(alu_a), 8);
    @(negedge clk);
    check("t3_exec3_op", int'(alu_op), 5);
    check("t3_exec3_a", int'(alu_a), 9);
    @(negedge clk);
    check("t3_valid", int'(res_valid), 1);
    check("t3_data", int'(res_data), 6);
    check("t3_count", int'(res_count), 3);
    @(posedge clk); #1;
    wait_idle();

    // Back-pressure: response stalled, FIFO fills, fifth command held off
    res_ready = 1'b0;
    push(0, 7, 1, 1);
    wait_result("t4a", 7, 0);
    push(0, 5, 1, 0);
    push(1, 1, 0, 0);
    push(1, 1, 0, 0);
    push(1, 1, 0, 1);
    cmd_op = '0; cmd_b = 4'd9; cmd_load = 1'b1; cmd_last = 1'b1; cmd_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t4_full_ready", int'(cmd_ready), 0);
      check("t4_stall_valid", int'(res_valid), 1);
      check("t4_stall_data", int'(res_data), 7);
      check("t4_stall_count", int'(res_count), 0);
      @(posedge clk); #1;
    end
    res_ready = 1'b1;
    @(negedge clk);
    check("t4_ready_at_handshake", int'(cmd_ready), 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("t4_ready_idle_full", int'(cmd_ready), 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("t4_ready_after_pop", int'(cmd_ready), 1);
    @(posedge clk);
    model_accept(0, 9, 1, 1);
    #1 cmd_valid = 1'b0;
    wait_result("t4b", 8, 3);
    wait_result("t4c", 9, 0);
    wait_idle();

    // Asynchronous reset in the middle of a sequence
    push(0, 1, 1, 0);
    push(1, 1, 0, 0);
    push(1, 1, 0, 0);
    check("t5_pre_a", int'(alu_a), 1);
    #2 rst_n = 1'b0;
    #1;
    check("t5_rst_a", int'(alu_a), 0);
    check("t5_rst_b", int'(alu_b), 0);
    check("t5_rst_op", int'(alu_op), 0);
    check("t5_rst_busy", int'(busy), 0);
    check("t5_rst_ready", int'(cmd_ready), 1);
    check("t5_rst_valid", int'(res_valid), 0);
    check("t5_rst_count", int'(res_count), 0);
    m_acc = 0;
    m_cnt = 0;
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("t5_after_busy", int'(busy), 0);
    @(posedge clk); #1;
    push(0, 2, 1, 0);
    push(1, 2, 0, 1);
    wait_result("t5", 4, 1);
    wait_idle();

    // Zero opcodes and ~B
    push(0, 9, 1, 0);
    push(0, 5, 0, 1);
    wait_result("t6_op0", 0, 1);
    push(0, 9, 1, 0);
    push(7, 5, 0, 1);
    wait_result("t6_op7", 0, 1);
    push(6, 5, 0, 1);
    wait_result("t6_op6", 10, 1);
    wait_idle();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t6_idle_b", int'(alu_b), 0);
      check("t6_idle_op", int'(alu_op), 0);
    end
    @(posedge clk); #1;

    // Op count saturation: 260 adds of 1 -> acc 4, count 255
    push(0, 0, 1, 0);
    for (int i = 0; i < 260; i++) push(1, 1, 0, (i == 259));
    wait_result("t7_sat", 4, 255);
    wait_idle();

    check("exp_queue_drained", exp_data_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_issue_seq.md
Name: alu_issue_seq

Overview:
Operand/opcode issuer for the 4-bit combinational ALU. It accepts a stream of commands, buffers them in a small FIFO and drives the ALU's A/B/op inputs from an internal accumulator. It captures the ALU result back into the accumulator and returns the final result of each command sequence over a valid/ready response port. It sits between the control/test logic and the ALU instance.

Parameters:
WIDTH, 4, operand/result width (matches ALU data width)
OPW, 3, opcode width (matches ALU op width)
DEPTH, 4, command FIFO depth (power of 2)
CNTW, 8, op-counter width

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  FIFO can accept a command
cmd_op  in  OPW  ALU opcode
cmd_b  in  WIDTH  B operand, or load value
cmd_load  in  1  1 = load accumulator with cmd_b; cmd_op is ignored
cmd_last  in  1  final command of a sequence
alu_a  out  WIDTH  to ALU A (= accumulator)
alu_b  out  WIDTH  to ALU B
alu_op  out  OPW  to ALU op
alu_res  in  WIDTH  from ALU output (combinational)
res_valid  out  1  sequence result available
res_ready  in  1  consumer accepts result
res_data  out  WIDTH  final accumulator value
res_count  out  CNTW  ALU ops executed in the sequence (loads excluded)
busy  out  1  FSM not IDLE, or FIFO not empty

Behaviour:
- Opcodes: 000 zero, 001 A+B, 010 A-B, 011 A&B, 100 A|B, 101 ~A, 110 ~B, 111 zero. All arithmetic is modulo 2^WIDTH. Carry and borrow are dropped.
- Reset (async, rst_n=0): FIFO emptied, acc=0, count=0, FSM=IDLE, alu_b=0, alu_op=000, res_valid=0, res_data=0, res_count=0, cmd_ready=1, busy=0. Reset asserted mid-sequence aborts the sequence with no response.
- FIFO:
  - push when cmd_valid&cmd_ready.
  - cmd_ready = !full, independent of a same-cycle pop. A full FIFO never accepts, even while popping.
  - An entry stores {op, b, load, last}.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - If the FIFO is non-empty: pop, register entry into alu_b/alu_op/load_q/last_q (alu_op forced to 000 when load), go to EXEC.
  - Otherwise drive alu_b=0, alu_op=000.
- EXEC (exactly 1 cycle per command):
  - alu_a=acc (combinational from the acc register).
  - At the clock edge: acc<=cmd_b if load_q, else acc<=alu_res. count increments (saturating at 2^CNTW-1) only for non-load commands.
  - If last_q: go to RESP, load res_data=next acc, res_count=next count, res_valid=1.
  - Else if the FIFO is non-empty: pop the next entry in the same cycle and stay in EXEC. Back-to-back throughput is 1 command/clock, and the next command sees the updated acc.
  - Else go to IDLE.
- Latency: a command pushed into an empty idle block is popped the next cycle and executed the cycle after. res_valid rises 1 cycle after the EXEC of the last command.
- RESP:
  - Hold res_valid, res_data and res_count stable until res_ready=1.
  - On handshake: res_valid=0, acc=0, count=0, go to IDLE.
  - No pops while in RESP. The FIFO keeps accepting until full.
- res_valid high with res_ready high on the same cycle completes in one cycle. Next sequence's first pop occurs in IDLE the following cycle.
- busy = (state!=IDLE) | !empty.

Test Plan:
- Push {load,b=3},{op=001,b=1,last}, res_ready=1 -> res_valid pulse with res_data=4, res_count=1. Two consecutive EXEC cycles observed with alu_op 000 then 001.
- Push {load,b=1},{op=010,b=3,last} -> res_data=4'b1110 (wrap), res_count=1.
- Push load 4'b1100, and 4'b1010, or 4'b0001, op 101 last -> acc 1000, 1001, 0110; res_data=0110, res_count=3. EXEC runs 4 consecutive cycles.
- Hold res_ready=0 after a result; push 5 commands -> cmd_ready low after 4 accepted, 5th held off. res_data/res_count stable for 3 cycles. On release, the FIFO drains and the 5th is accepted the cycle after the first pop frees space.
- Reset pulse while in EXEC mid-sequence -> all outputs return to reset values asynchronously, FIFO empty. A new sequence {load 2, op 001 b=2 last} afterwards gives res_data=4.
- Op 000/111/110 with b=5: zero, zero, ~B -> 1010. Verify alu_b/alu_op stay 0/000 while IDLE.
